pdp_in_sched: RTL and testbench

- Input-side scheduler for the PDP core. Selects the per-layer data source: on-the-fly SDP stream or off-fly PDP RDMA stream.
- Admits data only between a layer start (op_en rising edge) and that layer's end beat. Queues one pending op_en.
- Drives the NaN-preproc stage through a one-deep output register. Reports per-layer beat counts and a layer-done pulse.

---
 rtl/pdp_in_sched.sv | 186 ++++++++++++++++++
 tb/tb_pdp_in_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_in_sched.sv
// PDP input scheduler: per-layer source select (SDP on-the-fly / RDMA off-fly) into a one-deep output register.
// Optional stall watchdog built in with `define PDP_IN_SCHED_TIMEOUT_EN.
module pdp_in_sched #(
    parameter int PD_W        = 20,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            reg2dp_op_en,
    input  logic            reg2dp_flying_mode,
    input  logic            sdp2pdp_valid,
    output logic            sdp2pdp_ready,
    input  logic [PD_W-1:0] sdp2pdp_pd,
    input  logic            pdp_rdma2dp_valid,
    output logic            pdp_rdma2dp_ready,
    input  logic [PD_W-1:0] pdp_rdma2dp_pd,
    output logic            sched2pre_pvld,
    input  logic            sched2pre_prdy,
    output logic [PD_W-1:0] sched2pre_pd,
    output logic            sched_layer_done,
    output logic [31:0]     dp2reg_layer_beats,
    output logic            dp2reg_op_en_ovf,
    output logic            dp2reg_sched_timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            src_q, src_d;
    logic            op_en_d1_q;
    logic            pending_q, pending_d;
    logic            pending_mode_q, pending_mode_d;
    logic            ovf_q, ovf_d;
    logic            pvld_q, pvld_d;
    logic [PD_W-1:0] pd_q, pd_d;
    logic [31:0]     cnt_q, cnt_d, cnt_inc;
    logic [31:0]     layer_beats_q, layer_beats_d;

    logic            op_en_rise, sel_vld, can_load, load, end_beat, drain_ok;
    logic            consume, start;
    logic [PD_W-1:0] sel_pd;

    always_comb begin
        op_en_rise = reg2dp_op_en & ~op_en_d1_q;
        sel_vld    = src_q ? pdp_rdma2dp_valid : sdp2pdp_valid;
        sel_pd     = src_q ? pdp_rdma2dp_pd : sdp2pdp_pd;
        can_load   = (~pvld_q | sched2pre_prdy) & (state_q == RUN);
        load       = sel_vld & can_load;
        end_beat   = sel_pd[PD_W-1] & sel_pd[PD_W-5];
        drain_ok   = (state_q == DRAIN) & (~pvld_q | sched2pre_prdy);
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    end

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        pending_d      = pending_q;
        pending_mode_d = pending_mode_q;
        ovf_d          = ovf_q;
        pvld_d         = pvld_q;
        pd_d           = pd_q;
        cnt_d          = cnt_q;
        layer_beats_d  = layer_beats_q;
        consume        = 1'b0;
        start          = 1'b0;

        case (state_q)
            IDLE: begin
                // A rise captured on the very cycle DRAIN exited lands here as pending
                if (pending_q) begin
                    state_d = RUN;
                    src_d   = pending_mode_q;
                    consume = 1'b1;
                    start   = 1'b1;
                end else if (op_en_rise) begin
                    state_d = RUN;
                    src_d   = reg2dp_flying_mode;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (load && end_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) begin
                    if (pending_q) begin
                        state_d = RUN;
                        src_d   = pending_mode_q;
                        consume = 1'b1;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (consume) pending_d = 1'b0;
        if (op_en_rise && !(state_q == IDLE && !pending_q)) begin
            if (pending_q) begin
                ovf_d = 1'b1;
            end else begin
                pending_d      = 1'b1;
                pending_mode_d = reg2dp_flying_mode;
            end
        end

        if (load) begin
            pvld_d = 1'b1;
            pd_d   = sel_pd;
            cnt_d  = cnt_inc;
            if (end_beat) begin
                layer_beats_d = cnt_inc;
                cnt_d         = 32'd0;
            end
        end else if (sched2pre_prdy) begin
            pvld_d = 1'b0;
        end
        if (start) cnt_d = 32'd0;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q        <= IDLE;
            src_q          <= 1'b0;
            op_en_d1_q     <= 1'b0;
            pending_q      <= 1'b0;
            pending_mode_q <= 1'b0;
            ovf_q          <= 1'b0;
            pvld_q         <= 1'b0;
            pd_q           <= '0;
            cnt_q          <= 32'd0;
            layer_beats_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            op_en_d1_q     <= reg2dp_op_en;
            pending_q      <= pending_d;
            pending_mode_q <= pending_mode_d;
            ovf_q          <= ovf_d;
            pvld_q         <= pvld_d;
            pd_q           <= pd_d;
            cnt_q          <= cnt_d;
            layer_beats_q  <= layer_beats_d;
        end
    end

    assign sdp2pdp_ready      = can_load & ~src_q;
    assign pdp_rdma2dp_ready  = can_load & src_q;
    assign sched2pre_pvld     = pvld_q;
    assign sched2pre_pd       = pd_q;
    assign sched_layer_done   = drain_ok;
    assign dp2reg_layer_beats = layer_beats_q;
    assign dp2reg_op_en_ovf   = ovf_q;

`ifdef PDP_IN_SCHED_TIMEOUT_EN
    logic [31:0] stall_q, stall_d;
    logic        tmo_q, tmo_d;

    always_comb begin
        stall_d = 32'd0;
        if (state_q == RUN && !load) stall_d = (&stall_q) ? stall_q : stall_q + 32'd1;
        tmo_d = tmo_q;
        // Equality, not >=, so a cleared flag stays clear while the same stall continues
        if (stall_d == 32'(TIMEOUT_CYC)) tmo_d = 1'b1;
        if (op_en_rise) tmo_d = 1'b0;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_q <= 32'd0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign dp2reg_sched_timeout = tmo_q;
`else
    // Threshold is meaningless without the watchdog; the term keeps the flag at 0
    assign dp2reg_sched_timeout = 1'b0 & (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_pdp_in_sched.sv
// Directed self-checking bench for pdp_in_sched; watchdog scenario selected by PDP_IN_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_pdp_in_sched;
    localparam int          PD_W   = 20;
    localparam logic [19:0] END_MK = 20'h88000;

    logic            clk = 1'b0;
    logic            rst_n, op_en, fly, sv, rv, prdy;
    logic            sready, rready, pvld, done, ovf, tmo;
    logic [PD_W-1:0] spd, rpd, pd;
    logic [31:0]     beats;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    pdp_in_sched #(.PD_W(PD_W), .TIMEOUT_CYC(16)) dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rst_n),
        .reg2dp_op_en        (op_en),
        .reg2dp_flying_mode  (fly),
        .sdp2pdp_valid       (sv),
        .sdp2pdp_ready       (sready),
        .sdp2pdp_pd          (spd),
        .pdp_rdma2dp_valid   (rv),
        .pdp_rdma2dp_ready   (rready),
        .pdp_rdma2dp_pd      (rpd),
        .sched2pre_pvld      (pvld),
        .sched2pre_prdy      (prdy),
        .sched2pre_pd        (pd),
        .sched_layer_done    (done),
        .dp2reg_layer_beats  (beats),
        .dp2reg_op_en_ovf    (ovf),
        .dp2reg_sched_timeout(tmo)
    );

    function automatic logic [19:0] beat(input int i, input int n);
        return (i == n - 1) ? (END_MK | 20'(i)) : (20'h00100 + 20'(i));
    endfunction

    task automatic pulse_op_en(input logic mode);
        @(negedge clk); fly = mode; op_en = 1'b1;
        @(negedge clk); op_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_en = 0; fly = 0; sv = 0; rv = 0; prdy = 0; spd = '0; rpd = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (sready !== 1'b0) begin n_fail++; $display("FAIL rst_sready got %b want 0", sready); end
        n_chk++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready got %b want 0", rready); end
        n_chk++; if (pvld !== 1'b0) begin n_fail++; $display("FAIL rst_pvld got %b want 0", pvld); end
        n_chk++; if (pd !== '0) begin n_fail++; $display("FAIL rst_pd got %h want 0", pd); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_chk++; if (beats !== 32'd0) begin n_fail++; $display("FAIL rst_beats got %0d want 0", beats); end
        n_chk++; if (ovf !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b want 00", ovf, tmo); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_hold;
        rv = 1'b1; rpd = 20'h00123; prdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            n_chk++; if (rready !== 1'b0 || pvld !== 1'b0) begin n_fail++; $display("FAIL idle_hold rready/pvld got %b/%b want 0/0", rready, pvld); end
        end
        rv = 1'b0;
    endtask

    task automatic test_rdma_layer;
        int k = 0, done_cnt = 0;
        logic acc_prev = 1'b0, acc;
        logic [19:0] acc_pd = '0;
        pulse_op_en(1'b1);
        for (int cyc = 0; cyc < 12; cyc++) begin
            prdy = 1'b1; rv = (k < 8); rpd = beat(k, 8);
            #1;
            n_chk++; if (pvld !== acc_prev) begin n_fail++; $display("FAIL rdma_pvld cyc%0d got %b want %b", cyc, pvld, acc_prev); end
            if (acc_prev) begin
                n_chk++; if (pd !== acc_pd) begin n_fail++; $display("FAIL rdma_pd cyc%0d got %h want %h", cyc, pd, acc_pd); end
            end
            if (k < 8) begin
                n_chk++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rdma_rready cyc%0d got %b want 1", cyc, rready); end
            end
            n_chk++; if (sready !== 1'b0) begin n_fail++; $display("FAIL rdma_sready cyc%0d got %b want 0", cyc, sready); end
            if (done) done_cnt++;
            acc = rready & rv;
            acc_pd = rpd;
            acc_prev = acc;
            if (acc) k++;
            @(negedge clk);
        end
        rv = 1'b0;
        n_chk++; if (k !== 8) begin n_fail++; $display("FAIL rdma_accepted got %0d want 8", k); end
        n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rdma_done_pulses got %0d want 1", done_cnt); end
        n_chk++; if (beats !== 32'd8) begin n_fail++; $display("FAIL rdma_layer_beats got %0d want 8", beats); end
    endtask

    task automatic test_sdp_toggle;
        int k = 0, c = 0, done_cnt = 0;
        logic hold_prev = 1'b0;
        logic [19:0] hold_pd = '0;
        pulse_op_en(1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            prdy = (cyc % 2 == 0); sv = (k < 6); spd = beat(k, 6);
            #1;
            n_chk++; if (rready !== 1'b0) begin n_fail++; $display("FAIL sdp_rready cyc%0d got %b want 0", cyc, rready); end
            if (hold_prev) begin
                n_chk++; if (pvld !== 1'b1 || pd !== hold_pd) begin n_fail++; $display("FAIL sdp_hold cyc%0d got %b/%h want 1/%h", cyc, pvld, pd, hold_pd); end
            end
            if (pvld && prdy) begin
                n_chk++; if (pd !== beat(c, 6)) begin n_fail++; $display("FAIL sdp_order beat%0d got %h want %h", c, pd, beat(c, 6)); end
                c++;
            end
            if (done) done_cnt++;
            hold_prev = pvld & ~prdy;
            hold_pd = pd;
            if (sready && sv) k++;
            @(negedge clk);
        end
        sv = 1'b0;
        n_chk++; if (k !== 6 || c !== 6) begin n_fail++; $display("FAIL sdp_count in/out got %0d/%0d want 6/6", k, c); end
        n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sdp_done_pulses got %0d want 1", done_cnt); end
        n_chk++; if (beats !== 32'd6) begin n_fail++; $display("FAIL sdp_layer_beats got %0d want 6", beats); end
    endtask

    task automatic test_pending;
        prdy = 1'b1;
        pulse_op_en(1'b1);
        for (int i = 0; i < 2; i++) begin
            rv = 1'b1; rpd = 20'h00200 + 20'(i);
            @(negedge clk);
        end
        rv = 1'b0;
        pulse_op_en(1'b0);
        #1;
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL pend_ovf_second got %b want 0", ovf); end
        pulse_op_en(1'b0);
        #1;
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL pend_ovf_third got %b want 1", ovf); end
        n_chk++; if (rready !== 1'b1 || sready !== 1'b0) begin n_fail++; $display("FAIL pend_src_a got r%b s%b want r1 s0", rready, sready); end
        rv = 1'b1; rpd = END_MK | 20'h5;
        @(negedge clk);
        rv = 1'b0;
        #1;
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL pend_done got %b want 1", done); end
        n_chk++; if (beats !== 32'd3) begin n_fail++; $display("FAIL pend_beats_a got %0d want 3", beats); end
        @(negedge clk); #1;
        n_chk++; if (sready !== 1'b1 || rready !== 1'b0) begin n_fail++; $display("FAIL pend_src_b got s%b r%b want s1 r0", sready, rready); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL pend_done_once got %b want 0", done); end
        sv = 1'b1; spd = END_MK | 20'h1;
        @(negedge clk);
        sv = 1'b0;
        #1;
        n_chk++; if (beats !== 32'd1 || done !== 1'b1) begin n_fail++; $display("FAIL pend_layer_b beats/done got %0d/%b want 1/1", beats, done); end
        @(negedge clk); #1;
        n_chk++; if (sready !== 1'b0) begin n_fail++; $display("FAIL pend_idle_sready got %b want 0", sready); end
    endtask

    task automatic test_end_hold_and_reset;
        prdy = 1'b1;
        pulse_op_en(1'b1);
        rv = 1'b1; rpd = END_MK;
        @(negedge clk);
        rpd = 20'h00300;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (rready !== 1'b0) begin n_fail++; $display("FAIL endhold_rready cyc%0d got %b want 0", i, rready); end
            @(negedge clk);
        end
        n_chk++; if (beats !== 32'd1) begin n_fail++; $display("FAIL endhold_beats got %0d want 1", beats); end
        pulse_op_en(1'b1);
        #1;
        n_chk++; if (rready !== 1'b1) begin n_fail++; $display("FAIL endhold_next_layer got %b want 1", rready); end
        prdy = 1'b0;
        @(negedge clk);
        rv = 1'b0;
        #1;
        n_chk++; if (pvld !== 1'b1 || pd !== 20'h00300) begin n_fail++; $display("FAIL endhold_load got %b/%h want 1/00300", pvld, pd); end
        #2; rst_n = 1'b0; #1;
        n_chk++; if (pvld !== 1'b0 || pd !== '0) begin n_fail++; $display("FAIL midrst_out got %b/%h want 0/0", pvld, pd); end
        n_chk++; if (beats !== 32'd0 || ovf !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_regs got %0d/%b/%b want 0/0/0", beats, ovf, done); end
        n_chk++; if (rready !== 1'b0 || sready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b%b want 00", rready, sready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_timeout;
        rv = 1'b0; sv = 1'b0; prdy = 1'b1;
        pulse_op_en(1'b1);
`ifdef PDP_IN_SCHED_TIMEOUT_EN
        repeat (15) @(negedge clk);
        #1;
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", tmo); end
        @(negedge clk); #1;
        n_chk++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set got %b want 1", tmo); end
        pulse_op_en(1'b1);
        #1;
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %b want 0", tmo); end
        @(negedge clk); #1;
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_stay_clear got %b want 0", tmo); end
`else
        repeat (20) @(negedge clk);
        #1;
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_disabled got %b want 0", tmo); end
`endif
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_idle_hold();
        test_rdma_layer();
        test_sdp_toggle();
        test_pending();
        test_end_hold_and_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
